reg_file_param: RTL and testbench
=================================

# reg_file_param

Parametrised multi-port register file for the processor datapath. It is the next generation of the team's 32-bit register primitives, generalised in data width and depth. It has two registered read ports and one write port, a hard-wired zero register, optional write-to-read bypass and per-byte write enables. It sits between the decode stage (addresses) and the ALU (operands), and is built from the team's register and decoder primitives or from equivalent behavioural storage.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, address width; depth = 2^ADDR_WIDTH entries.
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register.
- BYPASS, 1, 1 = same-cycle write data forwarded to read outputs; 0 = reads return pre-write contents.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  read strobe; both read outputs update at the edge when 1 and hold when 0.
- WRITE  in  1  write strobe.
- ADDR_R1  in  ADDR_WIDTH  read port 1 address.
- ADDR_R2  in  ADDR_WIDTH  read port 2 address.
- ADDR_W  in  ADDR_WIDTH  write address.
- DATA_W  in  DATA_WIDTH  write data.
- BYTE_EN  in  DATA_WIDTH/8  per-byte write enable; bit i covers DATA_W[8i+7:8i].
- DATA_R1  out  DATA_WIDTH  registered read data, port 1.
- DATA_R2  out  DATA_WIDTH  registered read data, port 2.

## Operation
- **Reset:** RESET=0 clears every entry and both DATA_R1/DATA_R2 to 0 immediately, independent of CLK. While RESET=0, READ and WRITE are ignored. Release is taken at the next rising edge with RESET=1.
- **Write:**
  - At a rising edge with WRITE=1, entry ADDR_W takes DATA_W bytes whose BYTE_EN bit is 1.
  - Bytes with BYTE_EN=0 keep their old value.
  - WRITE=1 with BYTE_EN all 0 is a no-op.
- **Zero register:** with ZERO_REG=1, writes to address 0 are discarded and address 0 always reads 0.
- **Read:**
  - At a rising edge with READ=1, DATA_R1 <= entry[ADDR_R1] and DATA_R2 <= entry[ADDR_R2].
  - With READ=0, both outputs hold their last values.
  - Both ports may use the same address; both then return the same value.
- **Simultaneous READ=1 and WRITE=1 to a matching address (per port):**
  - BYPASS=1: the output gets the merged word. Bytes with BYTE_EN=1 come from DATA_W; the rest come from the stored entry.
  - BYPASS=0: the output gets the stored pre-write entry. The entry still updates.
  - With ZERO_REG=1, address 0 never bypasses; it returns 0.
- **Out-of-range addresses** cannot occur, because depth is exactly 2^ADDR_WIDTH.

## Timing
- **Read latency:** 1 cycle. Addresses sampled at edge N appear on DATA_R* after edge N; they are stable through edge N+1.
- **Write latency:** 1 cycle. Data written at edge N is visible to a read sampled at edge N+1, or at edge N itself when BYPASS=1.
- **Reset values:** all outputs and all storage are 0.
- **Asynchronous reset mid-operation:** an in-progress write at the asserting edge is lost. Outputs go to 0 within the same cycle.
- **Input timing:** all inputs are sampled only on the rising edge. The outputs have no combinational path from inputs.

## Test plan
- **Reset:** assert RESET=0 mid-cycle after arbitrary writes, then release.
  - DATA_R1 and DATA_R2 go to 0 immediately, without waiting for a clock edge.
  - Reading every address after release returns 0.
- **Write/read:**
  - Write 0xDEADBEEF to addr 5, full BYTE_EN.
  - Next cycle: READ with ADDR_R1=5, ADDR_R2=5.
  - Both outputs are 0xDEADBEEF one edge later.
  - Then hold READ=0 for 3 cycles: the outputs stay at 0xDEADBEEF.
- **Byte enables:**
  - Addr 7 holds 0x11223344. Write 0xAABBCCDD with BYTE_EN=4'b0101.
  - A read of addr 7 returns 0x11BB33DD.
- **Zero register (ZERO_REG=1):**
  - Write 0xFFFFFFFF to addr 0.
  - A read of addr 0 on either port returns 0x00000000, including on a same-cycle bypass.
- **Bypass:**
  - Addr 3 holds 0x1. Same edge: WRITE 0x2 to addr 3, READ ADDR_R1=3, ADDR_R2=4.
  - BYPASS=1: DATA_R1 = 0x2. BYPASS=0: DATA_R1 = 0x1, and the next read of addr 3 returns 0x2.
  - DATA_R2 is unaffected in both cases.
- **Parametrisation:**
  - Run with DATA_WIDTH=16 and ADDR_WIDTH=3.
  - Write a distinct value to each of the 8 entries, then read them all back correctly.
  - Address 7 and address 0 behave per ZERO_REG.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised register file with two registered read ports and one byte-enabled write port.
// Optionally provides a hard-wired zero entry and same-cycle write-to-read forwarding.
module reg_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    READ,
  input  logic                    WRITE,
  input  logic [ADDR_WIDTH-1:0]   ADDR_R1,
  input  logic [ADDR_WIDTH-1:0]   ADDR_R2,
  input  logic [ADDR_WIDTH-1:0]   ADDR_W,
  input  logic [DATA_WIDTH-1:0]   DATA_W,
  input  logic [DATA_WIDTH/8-1:0] BYTE_EN,
  output logic [DATA_WIDTH-1:0]   DATA_R1,
  output logic [DATA_WIDTH-1:0]   DATA_R2
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd1_word;
  logic [DATA_WIDTH-1:0] rd2_word;
  logic [DATA_WIDTH-1:0] data_r1_q, data_r1_d;
  logic [DATA_WIDTH-1:0] data_r2_q, data_r2_d;
  logic                  write_allowed;

  // Word the write port would leave in ADDR_W: new bytes where enabled, old bytes elsewhere.
  always_comb begin
    merged_word = mem_q[ADDR_W];
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (BYTE_EN[i]) begin
        merged_word[8*i +: 8] = DATA_W[8*i +: 8];
      end
    end
  end

  always_comb begin
    write_allowed = WRITE && !(ZERO_REG && (ADDR_W == '0));
    mem_d = mem_q;
    if (write_allowed) begin
      mem_d[ADDR_W] = merged_word;
    end
  end

  // The zero entry is masked last so it also wins over forwarding.
  always_comb begin
    rd1_word = mem_q[ADDR_R1];
    rd2_word = mem_q[ADDR_R2];
    if (BYPASS && WRITE && (ADDR_W == ADDR_R1)) begin
      rd1_word = merged_word;
    end
    if (BYPASS && WRITE && (ADDR_W == ADDR_R2)) begin
      rd2_word = merged_word;
    end
    if (ZERO_REG && (ADDR_R1 == '0)) begin
      rd1_word = '0;
    end
    if (ZERO_REG && (ADDR_R2 == '0)) begin
      rd2_word = '0;
    end
    data_r1_d = READ ? rd1_word : data_r1_q;
    data_r2_d = READ ? rd2_word : data_r2_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_q     <= '{default: '0};
      data_r1_q <= '0;
      data_r2_q <= '0;
    end else begin
      mem_q     <= mem_d;
      data_r1_q <= data_r1_d;
      data_r2_q <= data_r2_d;
    end
  end

  assign DATA_R1 = data_r1_q;
  assign DATA_R2 = data_r2_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param: instance a is the default build, b disables
// the zero entry and forwarding, c is a narrow 16x8 build with the zero entry.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        rd, wr;
  logic [4:0]  ar1, ar2, aw;
  logic [31:0] dw;
  logic [3:0]  be;
  logic [31:0] a_r1, a_r2, b_r1, b_r2;

  logic        c_rd, c_wr;
  logic [2:0]  c_ar1, c_ar2, c_aw;
  logic [15:0] c_dw;
  logic [1:0]  c_be;
  logic [15:0] c_r1, c_r2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .CLK(clk), .RESET(reset_n), .READ(rd), .WRITE(wr),
    .ADDR_R1(ar1), .ADDR_R2(ar2), .ADDR_W(aw), .DATA_W(dw), .BYTE_EN(be),
    .DATA_R1(a_r1), .DATA_R2(a_r2)
  );

  reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .CLK(clk), .RESET(reset_n), .READ(rd), .WRITE(wr),
    .ADDR_R1(ar1), .ADDR_R2(ar2), .ADDR_W(aw), .DATA_W(dw), .BYTE_EN(be),
    .DATA_R1(b_r1), .DATA_R2(b_r2)
  );

  reg_file_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
    .CLK(clk), .RESET(reset_n), .READ(c_rd), .WRITE(c_wr),
    .ADDR_R1(c_ar1), .ADDR_R2(c_ar2), .ADDR_W(c_aw), .DATA_W(c_dw), .BYTE_EN(c_be),
    .DATA_R1(c_r1), .DATA_R2(c_r2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] cExpected(input int idx);
    return (idx == 0) ? 16'h0000 : 16'h1111 * 16'(idx + 1);
  endfunction

  initial begin
    rd = 0; wr = 0; ar1 = 0; ar2 = 0; aw = 0; dw = 0; be = 0;
    c_rd = 0; c_wr = 0; c_ar1 = 0; c_ar2 = 0; c_aw = 0; c_dw = 0; c_be = 0;

    #12;
    checkOutput("reset_a_r1", a_r1, 32'h0);
    checkOutput("reset_a_r2", a_r2, 32'h0);
    checkOutput("reset_b_r1", b_r1, 32'h0);
    checkOutput("reset_b_r2", b_r2, 32'h0);
    reset_n = 1;

    // Full-word write then dual read of the same address, then hold.
    wr = 1; aw = 5; dw = 32'hDEADBEEF; be = 4'hF;
    tick();
    wr = 0; rd = 1; ar1 = 5; ar2 = 5;
    tick();
    checkOutput("wr_rd_a_r1", a_r1, 32'hDEADBEEF);
    checkOutput("wr_rd_a_r2", a_r2, 32'hDEADBEEF);
    checkOutput("wr_rd_b_r1", b_r1, 32'hDEADBEEF);
    rd = 0; ar1 = 1; ar2 = 2;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("hold_a_r1_%0d", i), a_r1, 32'hDEADBEEF);
      checkOutput($sformatf("hold_a_r2_%0d", i), a_r2, 32'hDEADBEEF);
    end

    // Byte enables: only bytes 0 and 2 are replaced.
    wr = 1; aw = 7; dw = 32'h11223344; be = 4'hF;
    tick();
    dw = 32'hAABBCCDD; be = 4'b0101;
    tick();
    wr = 0; rd = 1; ar1 = 7; ar2 = 7;
    tick();
    checkOutput("byte_en_a_r1", a_r1, 32'h11BB33DD);
    checkOutput("byte_en_b_r2", b_r2, 32'h11BB33DD);
    wr = 1; aw = 7; dw = 32'hFFFFFFFF; be = 4'b0000;
    tick();
    checkOutput("be_zero_a_r1", a_r1, 32'h11BB33DD);
    checkOutput("be_zero_b_r1", b_r1, 32'h11BB33DD);
    wr = 0;
    tick();
    checkOutput("be_zero_after_a_r2", a_r2, 32'h11BB33DD);

    // Address 0: discarded on a, ordinary register on b.
    wr = 1; aw = 0; dw = 32'hFFFFFFFF; be = 4'hF; rd = 1; ar1 = 0; ar2 = 0;
    tick();
    checkOutput("zero_byp_a_r1", a_r1, 32'h0);
    checkOutput("zero_byp_a_r2", a_r2, 32'h0);
    checkOutput("zero_byp_b_r1", b_r1, 32'h0);
    wr = 0;
    tick();
    checkOutput("zero_read_a_r1", a_r1, 32'h0);
    checkOutput("zero_read_b_r1", b_r1, 32'hFFFFFFFF);

    // Forwarding on a, pre-write contents on b; port 2 unaffected.
    rd = 0; wr = 1; be = 4'hF; aw = 4; dw = 32'h44;
    tick();
    aw = 3; dw = 32'h1;
    tick();
    aw = 3; dw = 32'h2; rd = 1; ar1 = 3; ar2 = 4;
    tick();
    checkOutput("bypass_a_r1", a_r1, 32'h2);
    checkOutput("bypass_a_r2", a_r2, 32'h44);
    checkOutput("bypass_b_r1", b_r1, 32'h1);
    checkOutput("bypass_b_r2", b_r2, 32'h44);
    wr = 0;
    tick();
    checkOutput("after_bypass_a_r1", a_r1, 32'h2);
    checkOutput("after_bypass_b_r1", b_r1, 32'h2);

    // Asynchronous reset in the middle of a cycle.
    wr = 1; aw = 9; dw = 32'h12345678; rd = 1; ar1 = 5; ar2 = 7;
    tick();
    checkOutput("pre_reset_a_r1", a_r1, 32'hDEADBEEF);
    checkOutput("pre_reset_b_r2", b_r2, 32'h11BB33DD);
    #2 reset_n = 0;
    #1;
    checkOutput("async_rst_a_r1", a_r1, 32'h0);
    checkOutput("async_rst_a_r2", a_r2, 32'h0);
    checkOutput("async_rst_b_r1", b_r1, 32'h0);
    checkOutput("async_rst_b_r2", b_r2, 32'h0);
    aw = 10; dw = 32'hCAFEF00D;
    tick();
    checkOutput("rst_held_a_r1", a_r1, 32'h0);
    checkOutput("rst_held_b_r2", b_r2, 32'h0);
    wr = 0;
    #2 reset_n = 1;
    for (int i = 0; i < 16; i++) begin
      ar1 = 5'(i); ar2 = 5'(i + 16);
      tick();
      checkOutput($sformatf("post_rst_a_r1_%0d", i), a_r1, 32'h0);
      checkOutput($sformatf("post_rst_a_r2_%0d", i + 16), a_r2, 32'h0);
      checkOutput($sformatf("post_rst_b_r1_%0d", i), b_r1, 32'h0);
      checkOutput($sformatf("post_rst_b_r2_%0d", i + 16), b_r2, 32'h0);
    end
    rd = 0;

    // Narrow build: fill all 8 entries, read back on both ports.
    c_wr = 1; c_be = 2'b11;
    for (int i = 0; i < 8; i++) begin
      c_aw = 3'(i); c_dw = 16'h1111 * 16'(i + 1);
      tick();
    end
    c_wr = 0; c_rd = 1;
    for (int i = 0; i < 8; i++) begin
      c_ar1 = 3'(i); c_ar2 = 3'(7 - i);
      tick();
      checkOutput($sformatf("c_fill_r1_%0d", i), {16'h0, c_r1}, {16'h0, cExpected(i)});
      checkOutput($sformatf("c_fill_r2_%0d", 7 - i), {16'h0, c_r2}, {16'h0, cExpected(7 - i)});
    end
    c_wr = 1; c_aw = 7; c_dw = 16'hABCD; c_be = 2'b01; c_ar1 = 7; c_ar2 = 0;
    tick();
    checkOutput("c_top_byp_r1", {16'h0, c_r1}, 32'h000088CD);
    checkOutput("c_top_byp_r2", {16'h0, c_r2}, 32'h0);
    c_aw = 0; c_dw = 16'hFFFF; c_be = 2'b11; c_ar1 = 0; c_ar2 = 7;
    tick();
    checkOutput("c_zero_byp_r1", {16'h0, c_r1}, 32'h0);
    checkOutput("c_top_r2", {16'h0, c_r2}, 32'h000088CD);
    c_wr = 0; c_rd = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
